// File: rtl/crc_serial_engine_if.sv
// rtl/crc_serial_engine_if.sv - start/busy/done handshake and data bundle for the serial CRC engine
interface crc_serial_engine_if #(
  parameter int DATA_W = 7,
  parameter int CRC_W  = 5
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] data_in;
  logic [CRC_W-1:0]  crc_in;
  logic              busy;
  logic              done;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_ok;

  modport master (
    output start, mode, data_in, crc_in,
    input  busy, done, crc_out, crc_ok
  );

  modport slave (
    input  start, mode, data_in, crc_in,
    output busy, done, crc_out, crc_ok
  );
endinterface

// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - bit-serial CRC generate/check engine, one message per start
// Augmented-message division: data followed by CRC_W zeros (generate) or the received CRC (check).
module crc_serial_engine #(
  parameter int               DATA_W = 7,
  parameter int               CRC_W  = 5,
  parameter logic [CRC_W-1:0] POLY   = 5'h05,
  parameter logic [CRC_W-1:0] INIT   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  crc_serial_engine_if.slave  bus
);
  localparam int N     = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [N-1:0]     shreg;
  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] lfsr_next;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;

  // Feedback taps on the bit leaving the register, message bit enters at the bottom.
  assign lfsr_next = {lfsr[CRC_W-2:0], shreg[N-1]} ^ (lfsr[CRC_W-1] ? POLY : {CRC_W{1'b0}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      lfsr        <= '0;
      cnt         <= '0;
      mode_q      <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.crc_out <= '0;
      bus.crc_ok  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            shreg      <= {bus.data_in, (bus.mode ? bus.crc_in : {CRC_W{1'b0}})};
            lfsr       <= INIT;
            cnt        <= '0;
            mode_q     <= bus.mode;
            bus.busy   <= 1'b1;
            bus.crc_ok <= 1'b0;
            state      <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          lfsr  <= lfsr_next;
          shreg <= shreg << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            bus.crc_out <= lfsr_next;
            bus.crc_ok  <= mode_q & (lfsr_next == '0);
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
